// File: rtl/seq_pkg.sv
// Shared code constants, state encoding and successor helpers for the
// 000-101-111-110-011-010 sequence monitor.
package seq_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned CTR_W  = 4;
  localparam int unsigned ST_W   = 2;

  localparam logic [CODE_W-1:0] S0 = 3'b000;
  localparam logic [CODE_W-1:0] S1 = 3'b101;
  localparam logic [CODE_W-1:0] S2 = 3'b111;
  localparam logic [CODE_W-1:0] S3 = 3'b110;
  localparam logic [CODE_W-1:0] S4 = 3'b011;
  localparam logic [CODE_W-1:0] S5 = 3'b010;

  localparam logic [ST_W-1:0] HUNT   = 2'd0;
  localparam logic [ST_W-1:0] ACQ    = 2'd1;
  localparam logic [ST_W-1:0] LOCKED = 2'd2;

  // Illegal codes map to S0 so the result is always a legal code.
  function automatic logic [CODE_W-1:0] succ(input logic [CODE_W-1:0] code);
    logic [CODE_W-1:0] nxt;
    case (code)
      S0:      nxt = S1;
      S1:      nxt = S2;
      S2:      nxt = S3;
      S3:      nxt = S4;
      S4:      nxt = S5;
      S5:      nxt = S0;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

  function automatic logic is_legal(input logic [CODE_W-1:0] code);
    return (code != 3'b001) && (code != 3'b100);
  endfunction

endpackage

// File: rtl/seq_succ.sv
// Combinational successor lookup: next code in the sequence and legality flag.
module seq_succ
  import seq_pkg::*;
(
  input  logic [2:0] code,
  output logic [2:0] nxt,
  output logic       legal
);

  assign nxt   = succ(code);
  assign legal = is_legal(code);

endmodule

// File: rtl/seq_checker.sv
// Sequence monitor: hunts for 000, acquires LOCK_LEN correct steps, then
// flywheels through mismatches, pulsing err/wrap and counting errors.
module seq_checker
  import seq_pkg::*;
#(
  parameter int unsigned LOCK_LEN = 6,
  parameter int unsigned MISS_MAX = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       seq_in,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2:0]       expect_c
);

  localparam logic [CTR_W-1:0] LOCK_V = CTR_W'(LOCK_LEN);
  localparam logic [CTR_W-1:0] MISS_V = CTR_W'(MISS_MAX);

  logic [ST_W-1:0]   state, state_n;
  logic [2:0]        prev, prev_n;
  logic [CTR_W-1:0]  acq_cnt, acq_n;
  logic [CTR_W-1:0]  miss_cnt, miss_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              err_n, wrap_n, inc;
  logic [2:0]        prev_succ;
  logic              prev_legal;
  logic              match;

  seq_succ u_succ (
    .code  (prev),
    .nxt   (prev_succ),
    .legal (prev_legal)
  );

  assign match    = prev_legal && is_legal(seq_in) && (seq_in == prev_succ);
  assign expect_c = (state == HUNT) ? S0 : prev_succ;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= HUNT;
      prev     <= S0;
      acq_cnt  <= '0;
      miss_cnt <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
      wrap     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      prev     <= prev_n;
      acq_cnt  <= acq_n;
      miss_cnt <= miss_n;
      locked   <= (state_n == LOCKED);
      err      <= err_n;
      wrap     <= wrap_n;
      err_cnt  <= cnt_n;
    end
  end

  // Next-state and pulse decode; nothing advances while en is low.
  always_comb begin
    state_n = state;
    prev_n  = prev;
    acq_n   = acq_cnt;
    miss_n  = miss_cnt;
    err_n   = 1'b0;
    wrap_n  = 1'b0;
    inc     = 1'b0;
    if (en) begin
      case (state)
        HUNT: begin
          if (seq_in == S0) begin
            state_n = ACQ;
            prev_n  = S0;
            acq_n   = '0;
          end
        end
        ACQ: begin
          if (match) begin
            prev_n = seq_in;
            acq_n  = acq_cnt + CTR_W'(1);
            if (acq_n == LOCK_V) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else if (seq_in == S0) begin
            prev_n = S0;
            acq_n  = '0;
          end else begin
            state_n = HUNT;
          end
        end
        LOCKED: begin
          if (match) begin
            prev_n = seq_in;
            miss_n = '0;
            wrap_n = (seq_in == S0);
          end else begin
            // Flywheel: keep the expected sequence running past bad samples.
            prev_n = prev_succ;
            err_n  = 1'b1;
            inc    = 1'b1;
            miss_n = miss_cnt + CTR_W'(1);
            if (miss_n == MISS_V) begin
              state_n = HUNT;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
    if (clr) begin
      cnt_n = '0;
    end else if (inc && (err_cnt != {CNT_W{1'b1}})) begin
      cnt_n = err_cnt + CNT_W'(1);
    end else begin
      cnt_n = err_cnt;
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker with a 2-bit error counter so saturation
// is reachable in a few samples.
module tb_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [2:0] seq_in;
  logic       locked;
  logic       err;
  logic       wrap;
  logic [1:0] err_cnt;
  logic [2:0] expect_c;

  int total = 0;
  int bad   = 0;

  seq_checker #(.LOCK_LEN(6), .MISS_MAX(2), .CNT_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .seq_in   (seq_in),
    .locked   (locked),
    .err      (err),
    .wrap     (wrap),
    .err_cnt  (err_cnt),
    .expect_c (expect_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Drive one sample at the falling edge, let it be taken, settle past the edge.
  task automatic step(input logic [2:0] v, input logic e, input logic c);
    @(negedge clk);
    seq_in = v;
    en     = e;
    clr    = c;
    @(posedge clk);
    #1;
  endtask

  // Observed outputs after a sample: locked, err, wrap, err_cnt, expect.
  task automatic obs(input string tag, input logic l, input logic e, input logic w,
                     input logic [1:0] n, input logic [2:0] x);
    chk({tag, ".locked"}, 8'(locked), 8'(l));
    chk({tag, ".err"}, 8'(err), 8'(e));
    chk({tag, ".wrap"}, 8'(wrap), 8'(w));
    chk({tag, ".cnt"}, 8'(err_cnt), 8'(n));
    chk({tag, ".exp"}, 8'(expect_c), 8'(x));
  endtask

  // seq value, then expected locked, err, wrap, err_cnt, expect after the edge
  typedef struct {
    logic [2:0] v;
    logic       l, e, w;
    logic [1:0] n;
    logic [2:0] x;
  } vec_t;

  task automatic run(input string tag, input vec_t vs[$]);
    foreach (vs[i]) begin
      step(vs[i].v, 1'b1, 1'b0);
      obs($sformatf("%s[%0d]", tag, i), vs[i].l, vs[i].e, vs[i].w, vs[i].n, vs[i].x);
    end
  endtask

  initial begin
    vec_t lock1[$], wrap1[$], glitch[$], unlock[$], relock[$], sat[$], abort_q[$];
    rst = 1'b0; en = 1'b0; clr = 1'b0; seq_in = 3'd0;
    #12;
    obs("reset", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    rst = 1'b1;

    lock1 = '{'{0,0,0,0,0,5}, '{5,0,0,0,0,7}, '{7,0,0,0,0,6}, '{6,0,0,0,0,3},
              '{3,0,0,0,0,2}, '{2,0,0,0,0,0}, '{0,1,0,0,0,5}};
    run("lock", lock1);

    wrap1 = '{'{5,1,0,0,0,7}, '{7,1,0,0,0,6}, '{6,1,0,0,0,3}, '{3,1,0,0,0,2},
              '{2,1,0,0,0,0}, '{0,1,0,1,0,5}, '{5,1,0,0,0,7}};
    run("wrap", wrap1);

    glitch = '{'{7,1,0,0,0,6}, '{7,1,1,0,1,3}, '{3,1,0,0,1,2}};
    run("glitch", glitch);

    unlock = '{'{1,1,1,0,2,0}, '{1,0,1,0,3,0}};
    run("unlock", unlock);

    relock = '{'{0,0,0,0,3,5}, '{5,0,0,0,3,7}, '{7,0,0,0,3,6}, '{6,0,0,0,3,3},
               '{3,0,0,0,3,2}, '{2,0,0,0,3,0}, '{0,1,0,0,3,5}};
    run("relock", relock);

    sat = '{'{1,1,1,0,3,7}, '{7,1,0,0,3,6}, '{1,1,1,0,3,3}, '{3,1,0,0,3,2},
            '{1,1,1,0,3,0}, '{0,1,0,1,3,5}, '{1,1,1,0,3,7}, '{7,1,0,0,3,6}};
    run("sat", sat);

    // clear wins over the increment, error pulse still issued
    step(3'd1, 1'b1, 1'b1);
    obs("clr_err", 1'b1, 1'b1, 1'b0, 2'd0, 3'd3);
    step(3'd3, 1'b1, 1'b0);
    obs("clr_after", 1'b1, 1'b0, 1'b0, 2'd0, 3'd2);

    abort_q = '{'{1,1,1,0,1,0}, '{1,0,1,0,2,0}, '{0,0,0,0,2,5}, '{5,0,0,0,2,7},
                '{7,0,0,0,2,6}, '{4,0,0,0,2,0}, '{0,0,0,0,2,5}};
    run("abort", abort_q);

    relock = '{'{5,0,0,0,2,7}, '{7,0,0,0,2,6}, '{6,0,0,0,2,3}, '{3,0,0,0,2,2},
               '{2,0,0,0,2,0}, '{0,1,0,0,2,5}};
    run("relock2", relock);

    // enable low: garbage ignored, no pulses
    step(3'd1, 1'b0, 1'b0);
    obs("hold0", 1'b1, 1'b0, 1'b0, 2'd2, 3'd5);
    step(3'd4, 1'b0, 1'b0);
    obs("hold1", 1'b1, 1'b0, 1'b0, 2'd2, 3'd5);
    step(3'd7, 1'b0, 1'b0);
    obs("hold2", 1'b1, 1'b0, 1'b0, 2'd2, 3'd5);
    step(3'd7, 1'b0, 1'b1);
    obs("clr_noen", 1'b1, 1'b0, 1'b0, 2'd0, 3'd5);
    step(3'd5, 1'b1, 1'b0);
    obs("resume", 1'b1, 1'b0, 1'b0, 2'd0, 3'd7);
    step(3'd1, 1'b1, 1'b0);
    obs("pre_rst", 1'b1, 1'b1, 1'b0, 2'd1, 3'd6);

    // asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    obs("async_rst", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    step(3'd0, 1'b1, 1'b0);
    obs("in_rst", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
